// File: rtl/baud_pkg.sv
// Shared widths, default divisors and the config handshake state type for the
// fractional baud generator.
package baud_pkg;

  localparam int unsigned CNT_W  = 16;
  localparam int unsigned FRAC_W = 4;
  localparam int unsigned OSR    = 16;

  // Divisors for a 100 MHz system clock with x16 oversampling (int + frac/16)
  localparam int unsigned DIV_INT_9600    = 651;  // 651.0625
  localparam int unsigned DIV_FRAC_9600   = 1;
  localparam int unsigned DIV_INT_115200  = 54;   // 54.25
  localparam int unsigned DIV_FRAC_115200 = 4;
  localparam int unsigned DIV_INT_921600  = 6;    // 6.8125
  localparam int unsigned DIV_FRAC_921600 = 13;

  localparam int unsigned DEF_DIV_INT  = DIV_INT_115200;
  localparam int unsigned DEF_DIV_FRAC = DIV_FRAC_115200;

  typedef enum logic {
    S_IDLE    = 1'b0,
    S_PENDING = 1'b1
  } cfg_state_e;

endpackage

// File: rtl/baud_frac_div.sv
// Fractional clock divider: produces one os_tick per div_int + div_frac/2^FRAC_W
// cycles on average by stretching a period by one cycle on accumulator carry.
// Ports:
//   clk_in, rst_n        clock, async active-low reset
//   en                   run enable; low clears the period state
//   load                 replace the active divisor with load_int/load_frac
//   load_int, load_frac  divisor to load
//   run_c                combinational: generator running (en and div_int != 0)
//   wrap_c               combinational: this edge ends the current period
//   os_tick              registered one-cycle pulse after each period end
module baud_frac_div
  import baud_pkg::*;
#(
  parameter int unsigned CNT_W        = baud_pkg::CNT_W,
  parameter int unsigned FRAC_W       = baud_pkg::FRAC_W,
  parameter int unsigned DEF_DIV_INT  = baud_pkg::DEF_DIV_INT,
  parameter int unsigned DEF_DIV_FRAC = baud_pkg::DEF_DIV_FRAC
) (
  input  logic              clk_in,
  input  logic              rst_n,
  input  logic              en,
  input  logic              load,
  input  logic [CNT_W-1:0]  load_int,
  input  logic [FRAC_W-1:0] load_frac,
  output logic              run_c,
  output logic              wrap_c,
  output logic              os_tick
);

  localparam int unsigned PW = CNT_W + 1;
  localparam int unsigned AW = FRAC_W + 1;

  logic [CNT_W-1:0]  div_int;
  logic [FRAC_W-1:0] div_frac;
  logic [CNT_W-1:0]  cnt;
  logic [FRAC_W-1:0] acc;
  logic              ext;
  logic [PW-1:0]     per_m1;
  logic [AW-1:0]     acc_sum;

  // Last count of the current period; div_int != 0 whenever this is used
  assign run_c   = en && (div_int != '0);
  assign per_m1  = {1'b0, div_int} + PW'(ext) - PW'(1);
  assign wrap_c  = run_c && ({1'b0, cnt} == per_m1);
  assign acc_sum = {1'b0, acc} + {1'b0, div_frac};

  // Period counter, fractional accumulator and active divisor
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      div_int  <= CNT_W'(DEF_DIV_INT);
      div_frac <= FRAC_W'(DEF_DIV_FRAC);
      cnt      <= '0;
      acc      <= '0;
      ext      <= 1'b0;
      os_tick  <= 1'b0;
    end else begin
      os_tick <= wrap_c;
      if (load) begin
        div_int  <= load_int;
        div_frac <= load_frac;
        cnt      <= '0;
        acc      <= '0;
        ext      <= 1'b0;
      end else if (!run_c) begin
        cnt <= '0;
        acc <= '0;
        ext <= 1'b0;
      end else if (wrap_c) begin
        cnt <= '0;
        acc <= acc_sum[FRAC_W-1:0];
        ext <= acc_sum[FRAC_W];
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/baud_rate_gen.sv
// Programmable fractional baud generator with oversample tick, baud tick and a
// square baud clock. New divisors arrive over a valid/ready handshake and are
// applied only at a period boundary while running, so no short period occurs.
// Ports:
//   clk_in, rst_n               clock, async active-low reset
//   en                          run enable
//   cfg_valid / cfg_ready       divisor handshake; transfer on valid && ready
//   cfg_div_int, cfg_div_frac   offered divisor
//   os_tick                     one pulse per oversample period
//   baud_tick                   one pulse per OSR oversample periods
//   baud_clk                    ~50% duty baud clock
module baud_rate_gen
  import baud_pkg::*;
#(
  parameter int unsigned CNT_W        = baud_pkg::CNT_W,
  parameter int unsigned FRAC_W       = baud_pkg::FRAC_W,
  parameter int unsigned OSR          = baud_pkg::OSR,
  parameter int unsigned DEF_DIV_INT  = baud_pkg::DEF_DIV_INT,
  parameter int unsigned DEF_DIV_FRAC = baud_pkg::DEF_DIV_FRAC
) (
  input  logic              clk_in,
  input  logic              rst_n,
  input  logic              en,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [CNT_W-1:0]  cfg_div_int,
  input  logic [FRAC_W-1:0] cfg_div_frac,
  output logic              os_tick,
  output logic              baud_tick,
  output logic              baud_clk
);

  localparam int unsigned OS_W = $clog2(OSR);

  cfg_state_e        state;
  cfg_state_e        state_d;
  logic [CNT_W-1:0]  shadow_int;
  logic [FRAC_W-1:0] shadow_frac;
  logic              accept_c;
  logic              load_c;
  logic              run_c;
  logic              wrap_c;
  logic [OS_W-1:0]   os_cnt;
  logic [OS_W-1:0]   os_cnt_d;

  assign accept_c = cfg_valid && cfg_ready;

  baud_frac_div #(
    .CNT_W        (CNT_W),
    .FRAC_W       (FRAC_W),
    .DEF_DIV_INT  (DEF_DIV_INT),
    .DEF_DIV_FRAC (DEF_DIV_FRAC)
  ) u_div (
    .clk_in    (clk_in),
    .rst_n     (rst_n),
    .en        (en),
    .load      (load_c),
    .load_int  (shadow_int),
    .load_frac (shadow_frac),
    .run_c     (run_c),
    .wrap_c    (wrap_c),
    .os_tick   (os_tick)
  );

  // Handshake state register; cfg_ready tracks the next state
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      cfg_ready <= 1'b1;
    end else begin
      state     <= state_d;
      cfg_ready <= (state_d == S_IDLE);
    end
  end

  // Pending update waits for a period boundary unless the generator is stopped
  always_comb begin
    state_d = state;
    load_c  = 1'b0;
    case (state)
      S_IDLE: begin
        if (accept_c) state_d = S_PENDING;
      end
      S_PENDING: begin
        if (!run_c || wrap_c) begin
          load_c  = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Shadow register for the accepted divisor
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      shadow_int  <= '0;
      shadow_frac <= '0;
    end else if (accept_c) begin
      shadow_int  <= cfg_div_int;
      shadow_frac <= cfg_div_frac;
    end
  end

  // Oversample phase; survives divisor loads so baud phase continues
  always_comb begin
    os_cnt_d = os_cnt;
    if (!run_c)      os_cnt_d = '0;
    else if (wrap_c) os_cnt_d = os_cnt + OS_W'(1);
  end

  // Baud outputs; baud_clk follows the post-wrap phase so it moves only on wraps
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      os_cnt    <= '0;
      baud_tick <= 1'b0;
      baud_clk  <= 1'b0;
    end else begin
      os_cnt    <= os_cnt_d;
      baud_tick <= wrap_c && (os_cnt == OS_W'(OSR - 1));
      baud_clk  <= (os_cnt_d >= OS_W'(OSR / 2));
    end
  end

endmodule
